// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA output path.
//   logb2         - ceil(log2(n)), used to size counters
//   R/G/B fields  - bit positions of the 3-3-2 color format
//   BG_COLOR_DEF  - default background color in the visible area
//   SYNC_IDLE_DEF - default inactive level of hsync/vsync
//   sync_bundle_t - raw timing bundle carried through the delay line
package vga_pkg;

    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    localparam logic [7:0] BG_COLOR_DEF  = 8'b010_010_01;
    localparam logic       SYNC_IDLE_DEF = 1'b1;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic von;
    } sync_bundle_t;

    function automatic int logb2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: pix_en-gated shift register of DEPTH stages, WIDTH bits
// each. DEPTH = 0 degenerates to a wire.
//   mclk, reset_n - clock, asynchronous active-low reset (stages -> RST_VAL)
//   pix_en        - advance strobe
//   d / q         - input word / word delayed by DEPTH strobes
module sync_delay_line #(
    parameter int                DEPTH   = 2,
    parameter int                WIDTH   = 3,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             mclk,
    input  logic             reset_n,
    input  logic             pix_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else begin : g_shift
            logic [DEPTH-1:0][WIDTH-1:0] stg;

            always_ff @(posedge mclk or negedge reset_n) begin
                if (!reset_n) begin
                    stg <= {DEPTH{RST_VAL}};
                end else if (pix_en) begin
                    stg[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
                end
            end

            assign q = stg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_layer_mixer.sv
// vga_layer_mixer: fixed-priority compositor of NUM_LAYERS color streams
// with per-layer enable and frame-synchronous blinking. Sync/blank are
// delayed to match the layer generators and every output is registered.
//   mclk, reset_n                 - clock, asynchronous active-low reset
//   pix_en                        - pixel strobe; pipeline advances only on it
//   hsync_in, vsync_in, von_in    - raw timing from the sync generator
//   layer_color/valid             - per-layer pixel, layer i at [i*COLOR_W +: COLOR_W]
//   layer_enable, blink_mask      - per-layer config, usable at any time
//   color_out, hsync_out, vsync_out - registered, mutually aligned pins
//   frame_tick                    - one-mclk pulse at each vsync pulse start
//   blink_phase                   - 1 = blink-masked layers hidden
module vga_layer_mixer
    import vga_pkg::*;
#(
    parameter int                 NUM_LAYERS   = 4,
    parameter int                 COLOR_W      = 8,
    parameter logic [COLOR_W-1:0] BG_COLOR     = COLOR_W'(BG_COLOR_DEF),
    parameter int                 SYNC_DELAY   = 2,
    parameter int                 BLINK_FRAMES = 16,
    parameter logic               SYNC_IDLE    = SYNC_IDLE_DEF
) (
    input  logic                          mclk,
    input  logic                          reset_n,
    input  logic                          pix_en,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    input  logic                          von_in,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
    input  logic [NUM_LAYERS-1:0]         layer_valid,
    input  logic [NUM_LAYERS-1:0]         layer_enable,
    input  logic [NUM_LAYERS-1:0]         blink_mask,
    output logic [COLOR_W-1:0]            color_out,
    output logic                          hsync_out,
    output logic                          vsync_out,
    output logic                          frame_tick,
    output logic                          blink_phase
);

    localparam int CNT_W = (logb2(BLINK_FRAMES) < 1) ? 1 : logb2(BLINK_FRAMES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam sync_bundle_t SYNC_RST = '{hsync: SYNC_IDLE, vsync: SYNC_IDLE, von: 1'b0};

    sync_bundle_t sync_in, sync_dly;
    assign sync_in = '{hsync: hsync_in, vsync: vsync_in, von: von_in};

    // SYNC_DELAY stages here; the output registers below form the final stage.
    sync_delay_line #(
        .DEPTH   (SYNC_DELAY),
        .WIDTH   ($bits(sync_bundle_t)),
        .RST_VAL (SYNC_RST)
    ) u_sync_dly (
        .mclk    (mclk),
        .reset_n (reset_n),
        .pix_en  (pix_en),
        .d       (sync_in),
        .q       (sync_dly)
    );

    // Layer eligibility
    logic [NUM_LAYERS-1:0] elig;
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_elig
            assign elig[gi] = layer_valid[gi] & layer_enable[gi]
                            & ~(blink_phase & blink_mask[gi]);
        end
    endgenerate

    // Scan from the lowest priority up so the lowest eligible index wins.
    logic [COLOR_W-1:0] win_color;
    always_comb begin
        win_color = BG_COLOR;
        for (int i = NUM_LAYERS - 1; i >= 0; i--)
            if (elig[i]) win_color = layer_color[i*COLOR_W +: COLOR_W];
    end

    // Final-stage vsync leaving idle: compared against the current output
    // register, which holds the previous final-stage value.
    logic vs_edge;
    assign vs_edge = (vsync_out == SYNC_IDLE) && (sync_dly.vsync != SYNC_IDLE);

    logic [CNT_W-1:0] frame_cnt;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            color_out   <= '0;
            hsync_out   <= SYNC_IDLE;
            vsync_out   <= SYNC_IDLE;
            frame_tick  <= 1'b0;
            blink_phase <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_tick <= 1'b0;
            if (pix_en) begin
                hsync_out <= sync_dly.hsync;
                vsync_out <= sync_dly.vsync;
                color_out <= sync_dly.von ? win_color : '0;
                if (vs_edge) begin
                    frame_tick <= 1'b1;
                    if (frame_cnt == CNT_LAST) begin
                        frame_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_layer_mixer.sv
module tb_vga_layer_mixer;

    localparam int         NL   = 4;
    localparam int         CW   = 8;
    localparam int         SD   = 2;
    localparam int         BF   = 2;
    localparam logic       IDLE = 1'b1;
    localparam logic [7:0] BG   = 8'b010_010_01;

    logic              mclk = 1'b0;
    logic              reset_n = 1'b0;
    logic              pix_en = 1'b0;
    logic              hsync_in = IDLE, vsync_in = IDLE, von_in = 1'b0;
    logic [NL*CW-1:0]  layer_color = '0;
    logic [NL-1:0]     layer_valid = '0, layer_enable = '1, blink_mask = '0;
    logic [CW-1:0]     color_out;
    logic              hsync_out, vsync_out, frame_tick, blink_phase;

    always #5 mclk = ~mclk;

    vga_layer_mixer #(
        .NUM_LAYERS(NL), .COLOR_W(CW), .BG_COLOR(BG), .SYNC_DELAY(SD),
        .BLINK_FRAMES(BF), .SYNC_IDLE(IDLE)
    ) dut (
        .mclk(mclk), .reset_n(reset_n), .pix_en(pix_en),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .von_in(von_in),
        .layer_color(layer_color), .layer_valid(layer_valid),
        .layer_enable(layer_enable), .blink_mask(blink_mask),
        .color_out(color_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .frame_tick(frame_tick), .blink_phase(blink_phase)
    );

    typedef struct { logic h; logic v; logic von; } syn_t;
    typedef struct { logic [7:0] color; logic hs; logic vs; logic ft; logic bp; } exp_t;

    syn_t hist[$];      // sync inputs not yet due at the output
    exp_t exp_q[$];     // scoreboard
    exp_t last_exp;
    int   frames;       // vsync pulses seen at the output since reset
    logic m_vs_final;
    int   n_checks = 0, n_fail = 0;
    logic strobe_seen = 1'b0;

    function automatic void chk(string nm, int act, int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endfunction

    function automatic void model_reset();
        syn_t s;
        s.h = IDLE; s.v = IDLE; s.von = 1'b0;
        hist.delete();
        for (int i = 0; i < SD; i++) hist.push_back(s);
        frames = 0;
        m_vs_final = IDLE;
        last_exp.color = 8'h00; last_exp.hs = IDLE; last_exp.vs = IDLE;
        last_exp.ft = 1'b0;     last_exp.bp = 1'b0;
    endfunction

    function automatic logic [7:0] pick(input logic bp, input logic [NL*CW-1:0] col,
                                        input logic [NL-1:0] vld, ena, msk);
        for (int i = 0; i < NL; i++)
            if (vld[i] && ena[i] && !(bp && msk[i])) return col[i*CW +: CW];
        return BG;
    endfunction

    // Drive one mclk cycle; on a strobe, predict the output it produces.
    task automatic pix(input logic en, h, v, von, input logic [NL*CW-1:0] col,
                       input logic [NL-1:0] vld, ena, msk);
        syn_t s, fin;
        exp_t e;
        logic bp_now, edge_;
        @(negedge mclk);
        pix_en = en; hsync_in = h; vsync_in = v; von_in = von;
        layer_color = col; layer_valid = vld; layer_enable = ena; blink_mask = msk;
        if (en) begin
            s.h = h; s.v = v; s.von = von;
            hist.push_back(s);
            fin = hist.pop_front();
            bp_now  = ((frames / BF) % 2) == 1;
            e.color = fin.von ? pick(bp_now, col, vld, ena, msk) : 8'h00;
            edge_   = (m_vs_final == IDLE) && (fin.v != IDLE);
            if (edge_) frames++;
            e.hs = fin.h; e.vs = fin.v; e.ft = edge_;
            e.bp = ((frames / BF) % 2) == 1;
            m_vs_final = fin.v;
            exp_q.push_back(e);
        end
    endtask

    always @(posedge mclk) strobe_seen <= reset_n && pix_en;

    // Monitor: after a strobe, compare against the scoreboard; otherwise
    // everything must hold and frame_tick must be low.
    always @(negedge mclk) begin
        exp_t e;
        if (reset_n) begin
            if (strobe_seen) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("color_out",   color_out,   e.color);
                    chk("hsync_out",   hsync_out,   e.hs);
                    chk("vsync_out",   vsync_out,   e.vs);
                    chk("frame_tick",  frame_tick,  e.ft);
                    chk("blink_phase", blink_phase, e.bp);
                    last_exp = e;
                end
            end else begin
                chk("hold_color",  color_out,   last_exp.color);
                chk("hold_hsync",  hsync_out,   last_exp.hs);
                chk("hold_vsync",  vsync_out,   last_exp.vs);
                chk("idle_tick",   frame_tick,  0);
                chk("hold_blink",  blink_phase, last_exp.bp);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_color"}, color_out,   0);
        chk({tag, "_hsync"}, hsync_out,   IDLE);
        chk({tag, "_vsync"}, vsync_out,   IDLE);
        chk({tag, "_tick"},  frame_tick,  0);
        chk({tag, "_blink"}, blink_phase, 0);
    endtask

    task automatic reset_mid();
        @(negedge mclk);
        #2;
        chk("queue_drained_before_reset", exp_q.size(), 0);
        reset_n = 1'b0;
        pix_en  = 1'b0;
        #1;
        check_reset_vals("async_reset");
        model_reset();
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NL*CW-1:0] col;
        logic [NL-1:0]    vld, ena, msk;
        logic             h, v, von;

        model_reset();
        repeat (3) @(posedge mclk);
        #1 check_reset_vals("reset");
        @(negedge mclk);
        #2 reset_n = 1'b1;

        // Blanking: layer 0 opaque white, von low then high.
        col = {8'h00, 8'h00, 8'h00, 8'hFF};
        for (int i = 0; i < 5; i++) pix(1, IDLE, IDLE, 0, col, 4'b0001, 4'hF, 4'h0);
        for (int i = 0; i < 5; i++) pix(1, IDLE, IDLE, 1, col, 4'b0001, 4'hF, 4'h0);

        // Priority, strobing every second cycle with hsync toggling.
        col = {8'hE0, 8'h55, 8'h1D, 8'hAA};
        for (int i = 0; i < 4; i++) begin
            pix(1, i[0], IDLE, 1, col, 4'b1010, 4'hF, 4'h0);
            pix(0, i[0], IDLE, 1, col, 4'b1010, 4'hF, 4'h0);
        end
        for (int i = 0; i < 4; i++) begin
            pix(1, i[0], IDLE, 1, col, 4'b1010, 4'b1101, 4'h0);
            pix(0, i[0], IDLE, 1, col, 4'b1010, 4'b1101, 4'h0);
        end
        for (int i = 0; i < 4; i++) begin
            pix(1, IDLE, IDLE, 1, col, 4'b0000, 4'hF, 4'h0);
            pix(0, IDLE, IDLE, 1, col, 4'b0000, 4'hF, 4'h0);
        end

        // Random frames: 6 lines x 12 pixels, vsync on lines 0-1, hsync on
        // pixels 0-1, visible from line 2 / pixel 3. Reset mid-frame once.
        ena = 4'hF; msk = 4'b0001;
        for (int f = 0; f < 7; f++) begin
            for (int l = 0; l < 6; l++) begin
                if ($urandom_range(0, 3) == 0) ena = 4'($urandom_range(0, 15));
                else ena = 4'hF;
                msk = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0001;
                for (int p = 0; p < 12; p++) begin
                    if (f == 3 && l == 3 && p == 5) reset_mid();
                    v   = (l < 2) ? ~IDLE : IDLE;
                    h   = (p < 2) ? ~IDLE : IDLE;
                    von = (l >= 2) && (p >= 3);
                    col = {$urandom, $urandom} ;
                    vld = 4'($urandom_range(0, 15));
                    if ($urandom_range(0, 1) == 1) vld[0] = 1'b1;
                    pix(1, h, v, von, col, vld, ena, msk);
                    repeat ($urandom_range(0, 2)) pix(0, h, v, von, col, vld, ena, msk);
                end
            end
        end

        repeat (3) pix(0, IDLE, IDLE, 0, '0, '0, 4'hF, 4'h0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
